// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the row-stationary PE.
package pe_pkg;

  localparam int unsigned PE_MAX_K = 5;
  localparam int unsigned PE_K_W   = $clog2(PE_MAX_K + 1);
  localparam int unsigned SAT_W    = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_F, S_FILL, S_WAIT_X, S_MAC, S_ADD, S_EMIT
  } pe_row_state_t;

  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned max_k);
    if (k == 0)     return 1;
    if (k > max_k)  return max_k;
    return k;
  endfunction

  // Adds two w-bit signed values held sign-extended in SAT_W bits (w < SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int unsigned w,
                                                      input logic sat);
    logic signed [SAT_W-1:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sat) begin
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
    end
    return (sum <<< (SAT_W - w)) >>> (SAT_W - w);
  endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// Signed DATA_WIDTH x DATA_WIDTH multiplier with MULT_LAT register stages and a valid sideband.
module pe_mult_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int MULT_LAT   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  output logic                           out_valid_o,
  output logic signed [2*DATA_WIDTH-1:0] p_o
);

  logic [MULT_LAT:1]                vld_pipe;
  logic signed [2*DATA_WIDTH-1:0]   prod_pipe [1:MULT_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      for (int i = 1; i <= MULT_LAT; i++) prod_pipe[i] <= '0;
    end else begin
      vld_pipe[1]  <= in_valid_i;
      prod_pipe[1] <= a_i * b_i;
      for (int i = 2; i <= MULT_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        prod_pipe[i] <= prod_pipe[i-1];
      end
    end
  end

  assign out_valid_o = vld_pipe[MULT_LAT];
  assign p_o         = prod_pipe[MULT_LAT];

endmodule

// File: rtl/pe_row_mac.sv
// Row-stationary PE: stationary filter taps, sliding 1-D ifmap window, serial MAC,
// one partial sum (ipsum + dot product) per window.
module pe_row_mac import pe_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_K      = PE_MAX_K,
  parameter int LEN_WIDTH  = 8,
  parameter int MULT_LAT   = 2,
  localparam int KW        = $clog2(MAX_K + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_start,
  input  logic [KW-1:0]                cfg_k,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic                         cfg_sat,
  input  logic                         fltr_valid,
  output logic                         fltr_ready,
  input  logic signed [DATA_WIDTH-1:0] fltr_data,
  input  logic                         ifmap_valid,
  output logic                         ifmap_ready,
  input  logic signed [DATA_WIDTH-1:0] ifmap_data,
  input  logic                         ipsum_valid,
  output logic                         ipsum_ready,
  input  logic signed [ACC_WIDTH-1:0]  ipsum_data,
  output logic                         opsum_valid,
  input  logic                         opsum_ready,
  output logic signed [ACC_WIDTH-1:0]  opsum_data,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(MAX_K + MULT_LAT + 1);

  pe_row_state_t                 state_q, state_d;
  logic [KW-1:0]                 k_q, ld_cnt_q;
  logic [LEN_WIDTH-1:0]          len_q, out_cnt_q;
  logic [CW-1:0]                 cyc_q;
  logic                          sat_q, done_q;
  logic signed [DATA_WIDTH-1:0]  fltr_q [MAX_K];
  logic signed [DATA_WIDTH-1:0]  win_q  [MAX_K];
  logic signed [ACC_WIDTH-1:0]   acc_q, res_q, res_d, prod_ext;
  logic signed [SAT_W-1:0]       sum_w;

  logic                          mul_iv, mul_ov;
  logic signed [DATA_WIDTH-1:0]  mul_a, mul_b;
  logic signed [2*DATA_WIDTH-1:0] mul_p;

  logic f_hs, x_hs, p_hs, o_hs;
  logic last_tap, last_fill, last_cyc, last_out;

  assign f_hs = fltr_valid  & fltr_ready;
  assign x_hs = ifmap_valid & ifmap_ready;
  assign p_hs = ipsum_valid & ipsum_ready;
  assign o_hs = opsum_valid & opsum_ready;

  assign last_tap  = (ld_cnt_q == k_q - KW'(1));
  assign last_fill = (ld_cnt_q == k_q - KW'(2));
  assign last_cyc  = (cyc_q == CW'(k_q) + CW'(MULT_LAT - 1));
  assign last_out  = (out_cnt_q + LEN_WIDTH'(1) == len_q);

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign opsum_data = res_q;

  always_comb begin
    state_d     = state_q;
    fltr_ready  = 1'b0;
    ifmap_ready = 1'b0;
    ipsum_ready = 1'b0;
    opsum_valid = 1'b0;
    case (state_q)
      S_IDLE:   if (cfg_start && cfg_len != '0) state_d = S_LOAD_F;
      S_LOAD_F: begin
        fltr_ready = 1'b1;
        if (f_hs && last_tap) state_d = (k_q == KW'(1)) ? S_WAIT_X : S_FILL;
      end
      S_FILL: begin
        ifmap_ready = 1'b1;
        if (x_hs && last_fill) state_d = S_WAIT_X;
      end
      S_WAIT_X: begin
        ifmap_ready = 1'b1;
        if (x_hs) state_d = S_MAC;
      end
      S_MAC:    if (last_cyc) state_d = S_ADD;
      S_ADD: begin
        ipsum_ready = 1'b1;
        if (p_hs) state_d = S_EMIT;
      end
      S_EMIT: begin
        opsum_valid = 1'b1;
        if (o_hs) state_d = last_out ? S_IDLE : S_WAIT_X;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Tap t of the current window is issued on MAC cycle t.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < MAX_K; i++) begin
      if (CW'(i) == cyc_q) begin
        mul_a = win_q[i];
        mul_b = fltr_q[i];
      end
    end
  end

  assign mul_iv   = (state_q == S_MAC) && (cyc_q < CW'(k_q));
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){mul_p[2*DATA_WIDTH-1]}}, mul_p};

  always_comb begin
    sum_w = sat_add({{(SAT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q},
                    {{(SAT_W-ACC_WIDTH){ipsum_data[ACC_WIDTH-1]}}, ipsum_data},
                    ACC_WIDTH, sat_q);
    res_d = sum_w[ACC_WIDTH-1:0];
  end

  pe_mult_pipe #(.DATA_WIDTH(DATA_WIDTH), .MULT_LAT(MULT_LAT)) u_mult (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (mul_iv),
    .a_i         (mul_a),
    .b_i         (mul_b),
    .out_valid_o (mul_ov),
    .p_o         (mul_p)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      ld_cnt_q  <= '0;
      len_q     <= '0;
      out_cnt_q <= '0;
      cyc_q     <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
      for (int i = 0; i < MAX_K; i++) begin
        fltr_q[i] <= '0;
        win_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      // Window slides toward index 0; the newest sample lands at K-1.
      if (x_hs) begin
        for (int i = 0; i < MAX_K - 1; i++)
          if (KW'(i + 1) < k_q) win_q[i] <= win_q[i+1];
        for (int i = 0; i < MAX_K; i++)
          if (KW'(i + 1) == k_q) win_q[i] <= ifmap_data;
      end
      case (state_q)
        S_IDLE: if (cfg_start) begin
          k_q       <= KW'(clamp_k(32'(cfg_k), MAX_K));
          len_q     <= cfg_len;
          sat_q     <= cfg_sat;
          ld_cnt_q  <= '0;
          out_cnt_q <= '0;
          done_q    <= (cfg_len == '0);
        end
        S_LOAD_F: if (f_hs) begin
          for (int i = 0; i < MAX_K; i++)
            if (KW'(i) == ld_cnt_q) fltr_q[i] <= fltr_data;
          ld_cnt_q <= last_tap ? '0 : ld_cnt_q + KW'(1);
        end
        S_FILL:   if (x_hs) ld_cnt_q <= ld_cnt_q + KW'(1);
        S_WAIT_X: if (x_hs) begin
          cyc_q <= '0;
          acc_q <= '0;
        end
        S_MAC: begin
          cyc_q <= cyc_q + CW'(1);
          if (mul_ov) acc_q <= acc_q + prod_ext;
        end
        S_ADD:    if (p_hs) res_q <= res_d;
        S_EMIT:   if (o_hs) begin
          out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
          done_q    <= last_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_mac.sv
// Directed plus randomized jobs for pe_row_mac, checked against a dot-product reference.
module tb_pe_row_mac;

  localparam int DW = 16, AW = 40, MK = 5, LW = 8, ML = 2, KW = 3;
  localparam longint HI = 64'sd549755813887;
  localparam longint LO = -64'sd549755813888;

  logic                 clk = 1'b0, rstn;
  logic                 cfg_start, cfg_sat;
  logic [KW-1:0]        cfg_k;
  logic [LW-1:0]        cfg_len;
  logic                 fltr_valid, fltr_ready, ifmap_valid, ifmap_ready;
  logic                 ipsum_valid, ipsum_ready, opsum_valid, opsum_ready, busy, done;
  logic signed [DW-1:0] fltr_data, ifmap_data;
  logic signed [AW-1:0] ipsum_data, opsum_data;

  int checks = 0, errors = 0;
  longint qf[$], qx[$], qp[$], qexp[$];

  pe_row_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MK), .LEN_WIDTH(LW), .MULT_LAT(ML)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_len(cfg_len),
    .cfg_sat(cfg_sat), .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready), .ipsum_data(ipsum_data),
    .opsum_valid(opsum_valid), .opsum_ready(opsum_ready), .opsum_data(opsum_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int keff(input int kc);
    if (kc == 0) return 1;
    if (kc > MK) return MK;
    return kc;
  endfunction

  function automatic longint fold(input longint s, input bit sat);
    if (sat) return (s > HI) ? HI : (s < LO) ? LO : s;
    if (s > HI) return s - 64'sd1099511627776;
    if (s < LO) return s + 64'sd1099511627776;
    return s;
  endfunction

  function automatic longint rnd16();
    return longint'($signed(16'($urandom)));
  endfunction

  function automatic logic [6:0] out_vec();
    return {fltr_ready, ifmap_ready, ipsum_ready, opsum_valid, busy, done, |opsum_data};
  endfunction

  task automatic idle_inputs();
    cfg_start = 0; fltr_valid = 0; ifmap_valid = 0; ipsum_valid = 0; opsum_ready = 0;
  endtask

  // Runs one job from a negedge; hold stalls the first result, abort pulls rstn mid-MAC.
  task automatic run_job(input int kc, input int len, input bit sat, input int hold,
                         input bit eager, input int abort_cyc, input string tag);
    int k, fi, xi, pi, oi, wx_cyc, hold_left;
    bit f_hs, x_hs, p_hs, o_hs, lat_done, finished;
    k = keff(kc);
    qexp.delete();
    for (int j = 0; j < len; j++) begin
      longint s;
      s = qp[j];
      for (int t = 0; t < k; t++) s += qf[t] * qx[j+t];
      qexp.push_back(fold(s, sat));
    end
    cfg_start = 1; cfg_k = KW'(kc); cfg_len = LW'(len); cfg_sat = sat;
    @(negedge clk);
    cfg_start = 0;
    if (len == 0) begin
      chk({tag, " done_len0"}, longint'(done), 1);
      chk({tag, " busy_len0"}, longint'(busy), 0);
      @(negedge clk);
      chk({tag, " done_clr"}, longint'(done), 0);
      return;
    end
    fi = 0; xi = 0; pi = 0; oi = 0; wx_cyc = -1; hold_left = hold;
    lat_done = 0; finished = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (abort_cyc > 0 && wx_cyc >= 0 && cyc == wx_cyc + abort_cyc) begin
        #2 rstn = 0;
        #1 chk({tag, " abort_outs"}, longint'(out_vec()), 0);
        idle_inputs();
        return;
      end
      fltr_valid  = (fi < k) && (eager || $urandom_range(3) != 0);
      fltr_data   = (fi < k) ? DW'(qf[fi]) : '0;
      ifmap_valid = (xi < k - 1 + len) && (eager || $urandom_range(3) != 0);
      ifmap_data  = (xi < k - 1 + len) ? DW'(qx[xi]) : '0;
      ipsum_valid = (pi < len) && (eager || $urandom_range(3) != 0);
      ipsum_data  = (pi < len) ? AW'(qp[pi]) : '0;
      cfg_start   = busy && ($urandom_range(5) == 0);
      cfg_k       = KW'($urandom);
      cfg_len     = LW'($urandom);
      if (opsum_valid && hold_left > 0) begin
        opsum_ready = 0;
        hold_left--;
        chk({tag, " stall_readys"}, longint'({ifmap_ready, ipsum_ready}), 0);
        chk({tag, " stall_data"}, longint'(opsum_data), qexp[oi]);
      end else begin
        opsum_ready = eager || ($urandom_range(2) != 0);
      end
      #1;
      if (eager && !lat_done && opsum_valid) begin
        chk({tag, " latency"}, longint'(cyc - wx_cyc), longint'(k + ML + 2));
        lat_done = 1;
      end
      f_hs = fltr_valid && fltr_ready;
      x_hs = ifmap_valid && ifmap_ready;
      p_hs = ipsum_valid && ipsum_ready;
      o_hs = opsum_valid && opsum_ready;
      if (f_hs) fi++;
      if (x_hs) begin
        if (xi == k - 1) wx_cyc = cyc;
        xi++;
      end
      if (p_hs) pi++;
      if (o_hs) begin
        chk($sformatf("%s opsum[%0d]", tag, oi), longint'(opsum_data), qexp[oi]);
        oi++;
      end
      @(negedge clk);
      if (oi == len) begin
        finished = 1;
        break;
      end
    end
    idle_inputs();
    if (!finished) begin
      checks++; errors++;
      $error("FAIL %s timeout: observed %0d results expected %0d", tag, oi, len);
      return;
    end
    chk({tag, " done"}, longint'(done), 1);
    chk({tag, " busy_end"}, longint'(busy), 0);
    chk({tag, " fltr_count"}, longint'(fi), longint'(k));
    @(negedge clk);
    chk({tag, " done_clr"}, longint'(done), 0);
  endtask

  initial begin
    rstn = 0; idle_inputs();
    cfg_k = '0; cfg_len = '0; cfg_sat = 0;
    fltr_data = '0; ifmap_data = '0; ipsum_data = '0;
    #12 chk("reset_outs", longint'(out_vec()), 0);
    @(negedge clk); rstn = 1;
    @(negedge clk);

    qf = '{1, 2, 3}; qx = '{1, 2, 3, 4, 5}; qp = '{0, 0, 0};
    run_job(3, 3, 0, 0, 1, 0, "k3_basic");

    qf = '{-1}; qx = '{-32768}; qp = '{0};
    run_job(1, 1, 0, 0, 1, 0, "k1_neg");

    qf = '{2}; qx = '{3}; qp = '{HI};
    run_job(1, 1, 1, 0, 0, 0, "sat_on");
    run_job(1, 1, 0, 0, 0, 0, "sat_off");

    qf = '{1, 2, 3}; qx = '{1, 2, 3, 4, 5}; qp = '{0, 0, 0};
    run_job(3, 3, 0, 10, 0, 0, "backpressure");

    qf = '{7}; qx = '{rnd16(), rnd16(), rnd16()}; qp = '{5, -5, 100};
    run_job(0, 3, 0, 0, 0, 0, "k0_as_k1");

    qf = '{rnd16(), rnd16(), rnd16(), rnd16(), rnd16()};
    qx.delete(); for (int i = 0; i < 6; i++) qx.push_back(rnd16());
    qp = '{1, 2};
    run_job(7, 2, 0, 0, 0, 0, "k7_clamp");

    run_job(3, 0, 0, 0, 0, 0, "len0");

    qf = '{1, 2, 3}; qx = '{1, 2, 3, 4, 5}; qp = '{0, 0, 0};
    run_job(3, 3, 0, 0, 1, 2, "abort");
    #20 rstn = 1;
    @(negedge clk);
    run_job(3, 3, 0, 0, 0, 0, "after_abort");

    for (int r = 0; r < 8; r++) begin
      int kc, len;
      bit sat;
      kc = $urandom_range(0, 7); len = $urandom_range(1, 6); sat = 1'($urandom);
      qf.delete(); qx.delete(); qp.delete();
      for (int i = 0; i < keff(kc); i++) qf.push_back(rnd16());
      for (int i = 0; i < keff(kc) - 1 + len; i++) qx.push_back(rnd16());
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(2))
          0:       qp.push_back(HI - longint'($urandom_range(1000)));
          1:       qp.push_back(LO + longint'($urandom_range(1000)));
          default: qp.push_back(longint'($signed({$urandom, $urandom})) >>> 24);
        endcase
      end
      run_job(kc, len, sat, $urandom_range(3), 0, 0, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
